// File: rtl/pc_seq_unit.sv
// -----------------------------------------------------------------------------
// pc_seq_unit
//
// Program-counter sequencer. Owns the fetch PC and computes the next fetch
// address from the decoded control-transfer inputs:
//   J/JAL : pseudo-direct target {pc_plus4[ADDR_W-1:28], jump_idx, 2'b00}
//   Bcc   : PC-relative target pc_plus4 + (sign_ext(br_off) << 2)
//   JR    : register target {jr_tgt[ADDR_W-1:2], 2'b00}
// When several controls are asserted together, jr > jump > br_taken.
// All arithmetic wraps modulo 2^ADDR_W.
//
// Build option:
//   PC_SEQ_DELAY_SLOT_EN - when defined, a control transfer takes effect after
//                          one delay-slot instruction. The target is parked in a
//                          pending register, and a control transfer found in
//                          the slot is dropped and flagged on slot_viol. When
//                          undefined, targets load directly and slot_viol is 0.
//
// Parameters:
//   ADDR_W    - PC width, 28..64
//   RESET_VEC - PC after reset, truncated or zero-extended to ADDR_W
//   IDX_W     - jump-index width, must be 26
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   stall      in   hold PC; all controls ignored this cycle
//   jump       in   J/JAL at pc
//   jump_idx   in   instr[25:0]
//   br_taken   in   conditional branch at pc resolved taken
//   br_off     in   instr[15:0], signed word offset
//   jr         in   JR/JALR at pc
//   jr_tgt     in   rs register value
//   pc         out  current fetch address (registered)
//   pc_plus4   out  pc + 4 (combinational)
//   link_addr  out  JAL/JALR return address (combinational)
//   redirect   out  1 for one cycle after pc was loaded with a non-sequential target
//   misalign   out  one-cycle pulse, accepted JR target had nonzero [1:0]
//   slot_viol  out  one-cycle pulse, control transfer found in a delay slot
// -----------------------------------------------------------------------------
module pc_seq_unit #(
    parameter int unsigned ADDR_W    = 32,
    parameter logic [63:0] RESET_VEC = 64'h0000_0000_0040_0000,
    parameter int unsigned IDX_W     = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              jump,
    input  logic [IDX_W-1:0]  jump_idx,
    input  logic              br_taken,
    input  logic [15:0]       br_off,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_tgt,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] link_addr,
    output logic              redirect,
    output logic              misalign,
    output logic              slot_viol
);

    if (ADDR_W < 28 || ADDR_W > 64) begin : g_bad_addr_w
        $error("pc_seq_unit: ADDR_W must be in 28..64");
    end
    if (IDX_W != 26) begin : g_bad_idx_w
        $error("pc_seq_unit: IDX_W must be 26");
    end

    localparam logic [ADDR_W-1:0] RST_PC = RESET_VEC[ADDR_W-1:0];
    // Low 28 bits replaced by a J target; the region bits above come from pc_plus4.
    // Written as a mask so ADDR_W == 28 needs no zero-width slice.
    localparam logic [ADDR_W-1:0] J_LO_MASK = ADDR_W'({28{1'b1}});

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              redirect_q, redirect_d;
    logic              misalign_q, misalign_d;

    logic [ADDR_W-1:0] j_tgt;
    logic [ADDR_W-1:0] b_tgt;
    logic [ADDR_W-1:0] r_tgt;
    logic [ADDR_W-1:0] br_disp;
    logic [ADDR_W-1:0] cti_tgt;
    logic              cti;
    logic              misalign_hit;

    assign pc_plus4 = pc_q + ADDR_W'(4);

    assign j_tgt   = (pc_plus4 & ~J_LO_MASK) | ADDR_W'({jump_idx, 2'b00});
    assign br_disp = {{(ADDR_W-18){br_off[15]}}, br_off, 2'b00};
    assign b_tgt   = pc_plus4 + br_disp;
    assign r_tgt   = {jr_tgt[ADDR_W-1:2], 2'b00};

    assign cti          = jr | jump | br_taken;
    assign misalign_hit = jr & (|jr_tgt[1:0]);

    always_comb begin
        cti_tgt = b_tgt;
        if (jr) begin
            cti_tgt = r_tgt;
        end else if (jump) begin
            cti_tgt = j_tgt;
        end
    end

`ifdef PC_SEQ_DELAY_SLOT_EN
    // state   | meaning
    // ST_SEQ  | no transfer pending; fetch proceeds sequentially
    // ST_SLOT | pc is the delay slot; pend_tgt_q is loaded on the next accepted cycle
    typedef enum logic {
        ST_SEQ  = 1'b0,
        ST_SLOT = 1'b1
    } slot_state_t;

    slot_state_t       state_q, state_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              slot_viol_q, slot_viol_d;

    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        pend_tgt_d  = pend_tgt_q;
        redirect_d  = 1'b0;
        misalign_d  = 1'b0;
        slot_viol_d = 1'b0;
        if (!stall) begin
            case (state_q)
                ST_SLOT: begin
                    pc_d        = pend_tgt_q;
                    redirect_d  = 1'b1;
                    state_d     = ST_SEQ;
                    pend_tgt_d  = '0;
                    slot_viol_d = cti;
                end
                default: begin
                    // The slot instruction is fetched either way.
                    pc_d = pc_plus4;
                    if (cti) begin
                        pend_tgt_d = cti_tgt;
                        state_d    = ST_SLOT;
                        misalign_d = misalign_hit;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SEQ;
            pend_tgt_q  <= '0;
            slot_viol_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_tgt_q  <= pend_tgt_d;
            slot_viol_q <= slot_viol_d;
        end
    end

    assign slot_viol = slot_viol_q;
    // Return address skips the delay slot.
    assign link_addr = pc_plus4 + ADDR_W'(4);
`else
    always_comb begin
        pc_d       = pc_q;
        redirect_d = 1'b0;
        misalign_d = 1'b0;
        if (!stall) begin
            if (cti) begin
                pc_d       = cti_tgt;
                redirect_d = 1'b1;
                misalign_d = misalign_hit;
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    assign slot_viol = 1'b0;
    assign link_addr = pc_plus4;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RST_PC;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc       = pc_q;
    assign redirect = redirect_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_seq_unit
//
// Directed testbench for pc_seq_unit (ADDR_W = 32, default reset vector).
// The driver applies one vector per cycle on the falling edge and queues the
// hand-computed outputs expected after the next rising edge; the monitor pops
// and compares one entry after every rising edge. Expectations follow the
// delay-slot build when PC_SEQ_DELAY_SLOT_EN is defined.
// -----------------------------------------------------------------------------
module tb_pc_seq_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
`ifdef PC_SEQ_DELAY_SLOT_EN
    localparam logic [31:0] LINK_OFF = 32'd8;
`else
    localparam logic [31:0] LINK_OFF = 32'd4;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        jump;
    logic [25:0] jump_idx;
    logic        br_taken;
    logic [15:0] br_off;
    logic        jr;
    logic [31:0] jr_tgt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] link_addr;
    logic        redirect;
    logic        misalign;
    logic        slot_viol;

    pc_seq_unit #(
        .ADDR_W (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .jump      (jump),
        .jump_idx  (jump_idx),
        .br_taken  (br_taken),
        .br_off    (br_off),
        .jr        (jr),
        .jr_tgt    (jr_tgt),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .link_addr (link_addr),
        .redirect  (redirect),
        .misalign  (misalign),
        .slot_viol (slot_viol)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        red;
        logic        mis;
        logic        sv;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expected entry per rising edge while the queue is non-empty.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc",        pc,                e.pc);
                chk("pc_plus4",  pc_plus4,          e.pc + 32'd4);
                chk("link_addr", link_addr,         e.pc + LINK_OFF);
                chk("redirect",  32'(redirect),     32'(e.red));
                chk("misalign",  32'(misalign),     32'(e.mis));
                chk("slot_viol", 32'(slot_viol),    32'(e.sv));
            end
        end
    end

    task automatic step(input logic s, input logic j, input logic [25:0] idx,
                        input logic b, input logic [15:0] off,
                        input logic r, input logic [31:0] t,
                        input logic [31:0] epc, input logic ered,
                        input logic emis, input logic esv);
        exp_t e;
        @(negedge clk);
        stall    = s;
        jump     = j;
        jump_idx = idx;
        br_taken = b;
        br_off   = off;
        jr       = r;
        jr_tgt   = t;
        e.pc  = epc;
        e.red = ered;
        e.mis = emis;
        e.sv  = esv;
        q.push_back(e);
    endtask

    task automatic idle(input logic [31:0] epc);
        step(1'b0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b0, 32'h0, epc, 1'b0, 1'b0, 1'b0);
    endtask

    // Control transfer at pc=cur with expected target tgt. In the delay-slot
    // build the slot instruction (cur+4) is fetched first.
    task automatic do_cti(input logic j, input logic [25:0] idx,
                          input logic b, input logic [15:0] off,
                          input logic r, input logic [31:0] t,
                          input logic [31:0] cur, input logic [31:0] tgt,
                          input logic emis);
`ifdef PC_SEQ_DELAY_SLOT_EN
        step(1'b0, j, idx, b, off, r, t, cur + 32'd4, 1'b0, emis, 1'b0);
        step(1'b0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b0, 32'h0, tgt, 1'b1, 1'b0, 1'b0);
`else
        step(1'b0, j, idx, b, off, r, t, tgt, 1'b1, emis, 1'b0);
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        stall    = 1'b0;
        jump     = 1'b0;
        jump_idx = 26'h0;
        br_taken = 1'b0;
        br_off   = 16'h0;
        jr       = 1'b0;
        jr_tgt   = 32'h0;

        // Reset state, sampled while rst_n is low.
        @(posedge clk);
        #1;
        chk("rst_pc",        pc,               RST_PC);
        chk("rst_link_addr", link_addr,        RST_PC + LINK_OFF);
        chk("rst_redirect",  32'(redirect),    32'h0);
        chk("rst_misalign",  32'(misalign),    32'h0);
        chk("rst_slot_viol", 32'(slot_viol),   32'h0);
        #1;
        rst_n = 1'b1;

        idle(32'h0040_0004);
        idle(32'h0040_0008);
        idle(32'h0040_000C);

        // jr beats jump; misaligned register target.
        do_cti(1'b1, 26'h3FF_FFFF, 1'b0, 16'h0, 1'b1, 32'h1234_5677,
               32'h0040_000C, 32'h1234_5674, 1'b1);
        idle(32'h1234_5678);

        do_cti(1'b0, 26'h0, 1'b0, 16'h0, 1'b1, 32'h9000_1000,
               32'h1234_5678, 32'h9000_1000, 1'b0);
        // Pseudo-direct jump keeps region bits of pc_plus4.
        do_cti(1'b1, 26'h000_0040, 1'b0, 16'h0, 1'b0, 32'h0,
               32'h9000_1000, 32'h9000_0100, 1'b0);

        do_cti(1'b0, 26'h0, 1'b0, 16'h0, 1'b1, 32'h0040_0020,
               32'h9000_0100, 32'h0040_0020, 1'b0);
        // Negative branch offset.
        do_cti(1'b0, 26'h0, 1'b1, 16'hFFFE, 1'b0, 32'h0,
               32'h0040_0020, 32'h0040_001C, 1'b0);
        do_cti(1'b0, 26'h0, 1'b0, 16'h0, 1'b1, 32'h0040_0020,
               32'h0040_001C, 32'h0040_0020, 1'b0);
        // Largest positive branch offset.
        do_cti(1'b0, 26'h0, 1'b1, 16'h7FFF, 1'b0, 32'h0,
               32'h0040_0020, 32'h0042_0020, 1'b0);

        // Stall ignores the jump and holds pc.
        step(1'b1, 1'b1, 26'h000_0040, 1'b0, 16'h0, 1'b0, 32'h0,
             32'h0042_0020, 1'b0, 1'b0, 1'b0);

        do_cti(1'b0, 26'h0, 1'b0, 16'h0, 1'b1, 32'h0000_0003,
               32'h0042_0020, 32'h0000_0000, 1'b1);
        // Stall clears the pulse outputs.
        step(1'b1, 1'b0, 26'h0, 1'b0, 16'h0, 1'b0, 32'h0,
             32'h0000_0000, 1'b0, 1'b0, 1'b0);

        // jump beats br_taken: jump target 0x40, branch would give 0x404.
        do_cti(1'b1, 26'h000_0010, 1'b1, 16'h0100, 1'b0, 32'h0,
               32'h0000_0000, 32'h0000_0040, 1'b0);

        // Wrap-around from all-ones-minus-3.
        do_cti(1'b0, 26'h0, 1'b0, 16'h0, 1'b1, 32'hFFFF_FFFC,
               32'h0000_0040, 32'hFFFF_FFFC, 1'b0);
        idle(32'h0000_0000);
        idle(32'h0000_0004);

        // jr beats br_taken.
        do_cti(1'b0, 26'h0, 1'b1, 16'h0001, 1'b1, 32'h0000_0100,
               32'h0000_0004, 32'h0000_0100, 1'b0);

`ifdef PC_SEQ_DELAY_SLOT_EN
        // Branch at 0x100 -> target 0x144; slot at 0x104 stalls 3 cycles
        // and then carries a jump that must be dropped and flagged.
        step(1'b0, 1'b0, 26'h0, 1'b1, 16'h0010, 1'b0, 32'h0,
             32'h0000_0104, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 26'h000_0100, 1'b0, 16'h0, 1'b0, 32'h0,
                 32'h0000_0104, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 26'h000_0100, 1'b0, 16'h0, 1'b0, 32'h0,
             32'h0000_0144, 1'b1, 1'b0, 1'b1);
        idle(32'h0000_0148);
`else
        do_cti(1'b0, 26'h0, 1'b1, 16'h0010, 1'b0, 32'h0,
               32'h0000_0100, 32'h0000_0144, 1'b0);
        idle(32'h0000_0148);
`endif

        // Asynchronous reset mid-cycle after a control transfer was accepted.
        @(negedge clk);
        jump     = 1'b1;
        jump_idx = 26'h000_0080;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc",        pc,             RST_PC);
        chk("async_rst_redirect",  32'(redirect),  32'h0);
        chk("async_rst_slot_viol", 32'(slot_viol), 32'h0);
        jump     = 1'b0;
        jump_idx = 26'h0;
        #1;
        rst_n = 1'b1;
        idle(32'h0040_0004);
        idle(32'h0040_0008);
        idle(32'h0040_000C);

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drain", 32'(q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
- Parametrised program-counter sequencer: it owns the fetch PC register and computes J/JAL pseudo-direct targets, conditional-branch PC-relative targets and JR register targets internally.
- Supports fetch stall and an optional MIPS branch delay slot.
- Sits between the decode/branch-compare logic and the instruction memory address port.
- Supplies the link address for JAL/JALR writeback.

Parameters:
- ADDR_W, 32, PC/address width; legal range 28..64.
- RESET_VEC, 32'h0040_0000, PC value on reset; truncated or zero-extended to ADDR_W.
- IDX_W, 26, jump-index width; fixed by the ISA, kept as a parameter for checks only.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  1 = hold PC this cycle; all control inputs are ignored.
- jump  in  1  J/JAL decoded for the instruction at pc.
- jump_idx  in  IDX_W  instr[25:0].
- br_taken  in  1  conditional branch resolved taken for the instruction at pc.
- br_off  in  16  instr[15:0], signed word offset.
- jr  in  1  JR/JALR decoded for the instruction at pc.
- jr_tgt  in  ADDR_W  rs register value.
- pc  out  ADDR_W  current fetch address (registered).
- pc_plus4  out  ADDR_W  pc + 4 (combinational from pc).
- link_addr  out  ADDR_W  return address for JAL/JALR.
- redirect  out  1  registered; 1 for one cycle after pc was loaded with a non-sequential target.
- misalign  out  1  registered one-cycle pulse; JR target had nonzero [1:0].
- slot_viol  out  1  registered one-cycle pulse; control transfer presented while a delay-slot target is pending.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_VEC; redirect=0, misalign=0, slot_viol=0.
  - pending valid=0; pending target=0.
  - Release takes effect on the first rising edge with rst_n=1.
- Arithmetic: all sums are modulo 2^ADDR_W. No overflow flag.
- Target computation:
  - J target = {pc_plus4[ADDR_W-1:28], jump_idx, 2'b00}.
  - B target = pc_plus4 + (sign_ext(br_off) << 2).
  - JR target = {jr_tgt[ADDR_W-1:2], 2'b00}.
  - misalign = |jr_tgt[1:0] when the JR is accepted.
- Priority when several controls are asserted in one cycle: jr > jump > br_taken. The lower-priority controls are ignored, with no error.
- stall=1:
  - pc, pending and all pulse outputs hold/clear as follows: pc holds; pending holds; redirect, misalign and slot_viol go to 0.
  - Controls are ignored; the instruction is re-presented later.
- stall=0, no control asserted, no pending: pc <= pc_plus4; redirect <= 0.
- Control-transfer handling without delay slot: see Optional Feature.
- link_addr is combinational:
  - pc_plus4 + 4 when DELAY_SLOT_EN is defined.
  - pc_plus4 otherwise.
- Wrap-around: pc = all-ones-minus-3 increments to 0; this is legal and not flagged.
- Reset mid-pending: the pending target is discarded and pc=RESET_VEC.

Optional Feature:
- Macro: PC_SEQ_DELAY_SLOT_EN.
- Defined (delay-slot mode). On an accepted cycle:
  - Pending valid: pc <= pending target; redirect <= 1; pending cleared.
    - If any control is also asserted (CTI in the delay slot), it is ignored and slot_viol <= 1.
  - No pending, control asserted: pc <= pc_plus4 (the slot instruction); target stored in pending; pending valid=1; redirect <= 0.
  - A stall between the CTI and the slot, or between the slot and the target, preserves pending.
- Not defined:
  - An accepted control loads its target directly into pc; redirect <= 1.
  - No pending register exists; slot_viol is tied to 0.

Test Plan:
- Reset, then 3 free cycles with ADDR_W=32 -> pc = 0x00400000, 0x00400004, 0x00400008, 0x0040000C; redirect=0 throughout.
- pc=0x9000_1000, jump=1, jump_idx=0x0000040 -> target 0x9000_0100.
  - No delay slot: next pc=0x9000_0100, redirect=1.
  - Delay slot: pc=0x9000_1004, then 0x9000_0100.
- pc=0x0040_0020, br_taken=1, br_off=16'hFFFE -> target 0x0040_001C. br_off=16'h7FFF -> target 0x0042_0020.
- jr=1 and jump=1 together, jr_tgt=0x1234_5677 -> pc=0x1234_5674, misalign pulses 1 for one cycle, jump ignored.
- Delay slot mode: branch accepted, stall held 3 cycles during the slot, then the slot carries jump=1 -> pc goes slot -> branch target; slot_viol=1 once; pc holds during stall.
- Assert rst_n=0 asynchronously mid-cycle with pending valid -> pc=RESET_VEC immediately (before the next edge); after release, pc increments sequentially with no stale redirect.
